// File: rtl/rv_load_store_unit.sv
// Multicycle RV32I load/store unit between the CPU control FSM and the data memory.
// Checks each access for illegal funct3, out-of-range and misaligned addresses, steers
// bytes and halfwords onto the correct lanes, and waits on a req/ack memory handshake.
// Optional feature macro: LSU_TIMEOUT_EN, which bounds the wait for mem_ack to TIMEOUT
// cycles and then reports a timeout fault.
module rv_load_store_unit #(
    parameter int unsigned ADDR_W  = 10,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              is_store,
    input  logic [2:0]        funct3,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    output logic              busy,
    output logic              done,
    output logic [31:0]       rdata,
    output logic              fault,
    output logic [1:0]        fault_cause,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-3:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack
);

    typedef enum logic [1:0] {StIdle, StReq, StDone, StFault} state_t;

    localparam logic [1:0] CauseMisaligned = 2'b01;
    localparam logic [1:0] CauseTimeout    = 2'b10;
    localparam logic [1:0] CauseIllegal    = 2'b11;

    state_t     state;
    logic       store_q;
    logic [2:0] f3_q;
    logic [1:0] off_q;

    logic        illegal;
    logic        misaligned;
    logic [3:0]  be_calc;
    logic [31:0] wdata_calc;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic [31:0] load_ext;

`ifdef LSU_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT + 1);
    logic [CntW-1:0] cnt;
`else
    // TIMEOUT only matters when the timeout feature is built in.
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
`endif

    // Access checks and lane steering computed from the request inputs.
    always_comb begin
        illegal = is_store ? (funct3 > 3'd2) : (funct3 == 3'd3 || funct3[2:1] == 2'b11);
        if ((addr >> ADDR_W) != 32'd0) begin
            illegal = 1'b1;
        end
        misaligned = (funct3[1:0] == 2'b01 && addr[0]) ||
                     (funct3[1:0] == 2'b10 && addr[1:0] != 2'b00);
        unique case (funct3[1:0])
            2'b00: begin
                be_calc    = 4'b0001 << addr[1:0];
                wdata_calc = {4{wdata[7:0]}};
            end
            2'b01: begin
                be_calc    = addr[1] ? 4'b1100 : 4'b0011;
                wdata_calc = {2{wdata[15:0]}};
            end
            default: begin
                be_calc    = 4'b1111;
                wdata_calc = wdata;
            end
        endcase
    end

    // Select the addressed lane of the read word and extend it per the latched funct3.
    always_comb begin
        unique case (off_q)
            2'd0:    lane_b = mem_rdata[7:0];
            2'd1:    lane_b = mem_rdata[15:8];
            2'd2:    lane_b = mem_rdata[23:16];
            default: lane_b = mem_rdata[31:24];
        endcase
        lane_h = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        unique case (f3_q)
            3'd0:    load_ext = {{24{lane_b[7]}}, lane_b};
            3'd1:    load_ext = {{16{lane_h[15]}}, lane_h};
            3'd4:    load_ext = {24'h0, lane_b};
            3'd5:    load_ext = {16'h0, lane_h};
            default: load_ext = mem_rdata;
        endcase
    end

    // Access FSM with registered handshake, status and memory-side outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= StIdle;
            store_q     <= 1'b0;
            f3_q        <= 3'd0;
            off_q       <= 2'd0;
            busy        <= 1'b0;
            done        <= 1'b0;
            rdata       <= 32'h0;
            fault       <= 1'b0;
            fault_cause <= 2'b00;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_be      <= 4'b0000;
            mem_wdata   <= 32'h0;
`ifdef LSU_TIMEOUT_EN
            cnt         <= '0;
`endif
        end else begin
            done  <= 1'b0;
            fault <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (start) begin
                        store_q     <= is_store;
                        f3_q        <= funct3;
                        off_q       <= addr[1:0];
                        busy        <= 1'b1;
                        fault_cause <= 2'b00;
                        if (illegal || misaligned) begin
                            // Faulting accesses finish next cycle without touching memory.
                            state       <= StFault;
                            done        <= 1'b1;
                            fault       <= 1'b1;
                            fault_cause <= illegal ? CauseIllegal : CauseMisaligned;
                        end else begin
                            state     <= StReq;
                            mem_req   <= 1'b1;
                            mem_we    <= is_store;
                            mem_addr  <= addr[ADDR_W-1:2];
                            mem_be    <= be_calc;
                            mem_wdata <= wdata_calc;
`ifdef LSU_TIMEOUT_EN
                            cnt       <= '0;
`endif
                        end
                    end
                end
                StReq: begin
                    if (mem_ack) begin
                        state   <= StDone;
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        done    <= 1'b1;
                        if (!store_q) begin
                            rdata <= load_ext;
                        end
`ifdef LSU_TIMEOUT_EN
                    end else if (cnt == CntW'(TIMEOUT - 1)) begin
                        state       <= StFault;
                        mem_req     <= 1'b0;
                        mem_we      <= 1'b0;
                        done        <= 1'b1;
                        fault       <= 1'b1;
                        fault_cause <= CauseTimeout;
                    end else begin
                        cnt <= cnt + 1'b1;
`endif
                    end
                end
                StDone: begin
                    state <= StIdle;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= StIdle;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rv_load_store_unit.sv
// Directed self-checking bench for rv_load_store_unit (ADDR_W=10, TIMEOUT=15).
module tb_rv_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        is_store;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] rdata;
    logic        fault;
    logic [1:0]  fault_cause;
    logic        mem_req;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    int pass_cnt = 0;
    int total_cnt = 0;

    rv_load_store_unit #(.ADDR_W(10), .TIMEOUT(15)) dut (
        .clk(clk), .rst(rst), .start(start), .is_store(is_store), .funct3(funct3),
        .addr(addr), .wdata(wdata), .busy(busy), .done(done), .rdata(rdata),
        .fault(fault), .fault_cause(fault_cause), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request in the current cycle (cycle 0); returns sampled in cycle 1.
    task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd);
        is_store = st;
        funct3   = f3;
        addr     = a;
        wdata    = wd;
        start    = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; is_store = 1'b0; funct3 = 3'd0; addr = 32'h0;
        wdata = 32'h0; mem_rdata = 32'h0; mem_ack = 1'b0;
        tick(); tick();
        total_cnt++;
        if ({busy, done, fault, fault_cause, mem_req, mem_we} !== 7'b0 || rdata !== 32'h0 ||
            mem_addr !== 8'h0 || mem_be !== 4'h0 || mem_wdata !== 32'h0)
            $display("FAIL reset: busy=%b done=%b fault=%b cause=%b req=%b we=%b rdata=%h be=%b, required all zero",
                     busy, done, fault, fault_cause, mem_req, mem_we, rdata, mem_be);
        else pass_cnt++;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_lb();
        issue(1'b0, 3'd0, 32'h003, 32'h0);
        total_cnt++;
        if (mem_req !== 1'b1 || mem_be !== 4'b1000 || mem_we !== 1'b0 || mem_addr !== 8'd0 ||
            busy !== 1'b1)
            $display("FAIL lb_req: req=%b be=%b we=%b maddr=%0d busy=%b, required 1 1000 0 0 1",
                     mem_req, mem_be, mem_we, mem_addr, busy);
        else pass_cnt++;
        mem_rdata = 32'h80FF_FF12;
        mem_ack   = 1'b1;
        tick();
        mem_ack = 1'b0;
        total_cnt++;
        if (done !== 1'b1 || fault !== 1'b0 || rdata !== 32'hFFFF_FF80 || mem_req !== 1'b0)
            $display("FAIL lb_done: done=%b fault=%b rdata=%h req=%b, required 1 0 ffffff80 0",
                     done, fault, rdata, mem_req);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (done !== 1'b0 || busy !== 1'b0)
            $display("FAIL lb_idle: done=%b busy=%b, required 0 0", done, busy);
        else pass_cnt++;
    endtask

    task automatic test_sh();
        issue(1'b1, 3'd1, 32'h006, 32'h0000_BEEF);
        total_cnt++;
        if (mem_we !== 1'b1 || mem_be !== 4'b1100 || mem_wdata !== 32'hBEEF_BEEF ||
            mem_addr !== 8'd1 || mem_req !== 1'b1)
            $display("FAIL sh_req: we=%b be=%b wdata=%h maddr=%0d req=%b, required 1 1100 beefbeef 1 1",
                     mem_we, mem_be, mem_wdata, mem_addr, mem_req);
        else pass_cnt++;
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        total_cnt++;
        if (done !== 1'b1 || fault !== 1'b0 || rdata !== 32'hFFFF_FF80)
            $display("FAIL sh_done: done=%b fault=%b rdata=%h, required 1 0 ffffff80",
                     done, fault, rdata);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_misaligned();
        issue(1'b0, 3'd2, 32'h002, 32'h0);
        total_cnt++;
        if (done !== 1'b1 || fault !== 1'b1 || fault_cause !== 2'b01 || mem_req !== 1'b0 ||
            busy !== 1'b1 || rdata !== 32'hFFFF_FF80)
            $display("FAIL misaligned: done=%b fault=%b cause=%b req=%b busy=%b rdata=%h, required 1 1 01 0 1 ffffff80",
                     done, fault, fault_cause, mem_req, busy, rdata);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (done !== 1'b0 || mem_req !== 1'b0 || busy !== 1'b0 || fault_cause !== 2'b01)
            $display("FAIL misaligned_after: done=%b req=%b busy=%b cause=%b, required 0 0 0 01",
                     done, mem_req, busy, fault_cause);
        else pass_cnt++;
    endtask

    task automatic test_illegal();
        logic [31:0] a_tab [3] = '{32'h010, 32'h010, 32'h401};
        logic [2:0]  f_tab [3] = '{3'd3, 3'd4, 3'd2};
        logic        s_tab [3] = '{1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 3; i++) begin
            issue(s_tab[i], f_tab[i], a_tab[i], 32'h0);
            total_cnt++;
            if (done !== 1'b1 || fault !== 1'b1 || fault_cause !== 2'b11 || mem_req !== 1'b0)
                $display("FAIL illegal_%0d: done=%b fault=%b cause=%b req=%b, required 1 1 11 0",
                         i, done, fault, fault_cause, mem_req);
            else pass_cnt++;
            tick();
        end
    endtask

    task automatic test_lhu();
        int busy_cycles = 0;
        int done_cyc = 0;
        logic [31:0] got = 32'h0;
        is_store = 1'b0; funct3 = 3'd5; addr = 32'h004; start = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            tick();
            start     = 1'b0;
            mem_ack   = (i == 3);
            mem_rdata = 32'h1234_F00D;
            if (busy) busy_cycles++;
            if (done) begin
                done_cyc = i;
                got = rdata;
            end
        end
        mem_ack = 1'b0;
        total_cnt++;
        if (done_cyc != 4 || got !== 32'h0000_F00D)
            $display("FAIL lhu_done: done_cycle=%0d rdata=%h, required 4 0000f00d", done_cyc, got);
        else pass_cnt++;
        total_cnt++;
        if (busy_cycles != 4)
            $display("FAIL lhu_busy: busy_cycles=%0d, required 4", busy_cycles);
        else pass_cnt++;
    endtask

    task automatic test_timeout();
        int req_cycles = 0;
        int done_cyc = 0;
        int cyc = 1;
        logic f = 1'b0;
        logic [1:0] c = 2'b00;
        issue(1'b0, 3'd2, 32'h010, 32'h0);
        while (cyc <= 20 && done_cyc == 0) begin
            if (mem_req) req_cycles++;
            if (done) begin
                done_cyc = cyc;
                f = fault;
                c = fault_cause;
            end else begin
                tick();
                cyc++;
            end
        end
`ifdef LSU_TIMEOUT_EN
        total_cnt++;
        if (done_cyc != 16 || req_cycles != 15 || f !== 1'b1 || c !== 2'b10)
            $display("FAIL timeout: done_cycle=%0d req_cycles=%0d fault=%b cause=%b, required 16 15 1 10",
                     done_cyc, req_cycles, f, c);
        else pass_cnt++;
        tick();
`else
        total_cnt++;
        if (done_cyc != 0 || mem_req !== 1'b1)
            $display("FAIL no_timeout: done_cycle=%0d req=%b, required 0 1", done_cyc, mem_req);
        else pass_cnt++;
        mem_rdata = 32'h0000_0001;
        mem_ack   = 1'b1;
        tick();
        mem_ack = 1'b0;
        total_cnt++;
        if (done !== 1'b1 || fault !== 1'b0 || rdata !== 32'h0000_0001)
            $display("FAIL no_timeout_ack: done=%b fault=%b rdata=%h, required 1 0 00000001",
                     done, fault, rdata);
        else pass_cnt++;
        tick();
`endif
    endtask

    task automatic test_reset_mid();
        issue(1'b0, 3'd2, 32'h00C, 32'h0);
        total_cnt++;
        if (mem_req !== 1'b1)
            $display("FAIL rstmid_req: req=%b, required 1", mem_req);
        else pass_cnt++;
        #2 rst = 1'b1;
        #1;
        total_cnt++;
        if (mem_req !== 1'b0 || busy !== 1'b0)
            $display("FAIL rstmid_drop: req=%b busy=%b, required 0 0", mem_req, busy);
        else pass_cnt++;
        tick();
        rst = 1'b0;
        tick();
        issue(1'b0, 3'd2, 32'h008, 32'h0);
        total_cnt++;
        if (mem_req !== 1'b1 || mem_addr !== 8'd2 || mem_be !== 4'b1111)
            $display("FAIL rstmid_next_req: req=%b maddr=%0d be=%b, required 1 2 1111",
                     mem_req, mem_addr, mem_be);
        else pass_cnt++;
        mem_rdata = 32'hCAFE_F00D;
        mem_ack   = 1'b1;
        tick();
        mem_ack = 1'b0;
        total_cnt++;
        if (done !== 1'b1 || fault !== 1'b0 || rdata !== 32'hCAFE_F00D)
            $display("FAIL rstmid_next_done: done=%b fault=%b rdata=%h, required 1 0 cafef00d",
                     done, fault, rdata);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_back_to_back();
        // LBU lane 1, then LH at offset 2 started in the cycle right after done.
        issue(1'b0, 3'd4, 32'h001, 32'h0);
        mem_rdata = 32'h0000_9A00;
        mem_ack   = 1'b1;
        tick();
        mem_ack = 1'b0;
        total_cnt++;
        if (done !== 1'b1 || rdata !== 32'h0000_009A)
            $display("FAIL b2b_lbu: done=%b rdata=%h, required 1 0000009a", done, rdata);
        else pass_cnt++;
        tick();
        issue(1'b0, 3'd1, 32'h002, 32'h0);
        total_cnt++;
        if (mem_req !== 1'b1 || mem_be !== 4'b1100)
            $display("FAIL b2b_accept: req=%b be=%b, required 1 1100", mem_req, mem_be);
        else pass_cnt++;
        mem_rdata = 32'h8001_0000;
        mem_ack   = 1'b1;
        tick();
        mem_ack = 1'b0;
        total_cnt++;
        if (done !== 1'b1 || rdata !== 32'hFFFF_8001)
            $display("FAIL b2b_lh: done=%b rdata=%h, required 1 ffff8001", done, rdata);
        else pass_cnt++;
        tick();
        // Stray ack while idle must not start anything.
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        total_cnt++;
        if (done !== 1'b0 || busy !== 1'b0 || rdata !== 32'hFFFF_8001)
            $display("FAIL idle_ack: done=%b busy=%b rdata=%h, required 0 0 ffff8001",
                     done, busy, rdata);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_lb();
        test_sh();
        test_misaligned();
        test_illegal();
        test_lhu();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
